// File: rtl/prbs_gen_multi.sv
// prbs_gen_multi: multi-polynomial PRBS generator (PRBS-7/15/23/31), W bits per
// clock, valid/ready output, seed load and accepted-word counter.
// Optional feature macro: PRBS_ERR_INJECT_EN adds the inj_err port, which inverts
// the MSB of one registered word without disturbing the LFSR.
module prbs_gen_multi #(
  parameter int W     = 8,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [30:0]      seed,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
`ifdef PRBS_ERR_INJECT_EN
  ,
  input  logic             inj_err
`endif
);

  typedef enum logic {IDLE, RUN} state_e;

  // Significant-bit mask of the LFSR for a given polynomial selection.
  function automatic logic [30:0] len_mask(input logic [1:0] m);
    unique case (m)
      2'd0:    return 31'h0000_007F;
      2'd1:    return 31'h0000_7FFF;
      2'd2:    return 31'h007F_FFFF;
      default: return 31'h7FFF_FFFF;
    endcase
  endfunction

  state_e         state_q, state_d;
  logic [30:0]    s_q;
  logic [1:0]     mode_q;
  logic [W-1:0]   data_q;
  logic           valid_q;
  logic [CNT_W-1:0] cnt_q;

  logic [30:0]    s_d;
  logic [W-1:0]   word_d;
  logic [W-1:0]   word_out;
  logic [30:0]    seed_masked;
  logic [30:0]    seed_guarded;
  logic           take_word;

  // A fresh word is produced only in RUN, while enabled, when the output slot is free.
  assign take_word = (state_q == RUN) && enable && (!valid_q || out_ready);

  // Seed truncated to the selected length; an all-zero seed would lock the LFSR.
  assign seed_masked  = seed & len_mask(mode);
  assign seed_guarded = (seed_masked == '0) ? len_mask(mode) : seed_masked;

  // Chain W single-bit LFSR steps; the first feedback bit lands in the MSB.
  always_comb begin
    logic        fb;
    logic [30:0] mask;
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    s_d    = s_q;
    word_d = '0;
    fb     = 1'b0;
    mask   = len_mask(mode_q);
    for (int k = W - 1; k >= 0; k--) begin
      unique case (mode_q)
        2'd0:    fb = s_d[6]  ^ s_d[5];
        2'd1:    fb = s_d[14] ^ s_d[13];
        2'd2:    fb = s_d[22] ^ s_d[17];
        default: fb = s_d[30] ^ s_d[27];
      endcase
      s_d       = {s_d[29:0], fb} & mask;
      word_d[k] = fb;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic inj_pend_q;
  logic inj_now;

  assign inj_now = inj_err | inj_pend_q;

  // Flip only the MSB of the registered word; the LFSR itself is untouched.
  always_comb begin
    word_out        = word_d;
    word_out[W-1]   = word_d[W-1] ^ inj_now;
  end

  // Hold at most one injection request until a word is actually registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       inj_pend_q <= 1'b0;
    else if (load)      inj_pend_q <= 1'b0;
    else if (take_word) inj_pend_q <= 1'b0;
    else if (inj_err)   inj_pend_q <= 1'b1;
  end
`else
  assign word_out = word_d;
`endif

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: load forces IDLE; enable moves between IDLE and RUN.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (enable)  state_d = RUN;
        RUN:     if (!enable) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: LFSR, latched mode, output word register and handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_q     <= 31'h7FFF_FFFF;
      mode_q  <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      s_q     <= seed_guarded;
      mode_q  <= mode;
      valid_q <= 1'b0;
    end else if ((state_q == RUN) && !enable) begin
      valid_q <= 1'b0;
    end else if (take_word) begin
      s_q     <= s_d;
      data_q  <= word_out;
      valid_q <= 1'b1;
    end
  end

  // Accepted-word counter, cleared by load and wrapping naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  cnt_q <= '0;
    else if (load)                 cnt_q <= '0;
    else if (valid_q && out_ready) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign word_count = cnt_q;
  assign busy       = (state_q == RUN);

endmodule

// File: doc/prbs_gen_multi.md
# prbs_gen_multi

Parametrised, multi-polynomial PRBS pattern generator for the bit-error-ratio tester transmit path. It produces W bits of PRBS-7, PRBS-15, PRBS-23 or PRBS-31 per clock. Output is presented through a valid/ready handshake, with seed loading and a delivered-word counter. It feeds the serialiser and the error-checker reference path.

## Interface
Parameters:
- `W`, default 8: output word width in bits; legal range 1..32.
- `CNT_W`, default 32: width of the delivered-word counter.

Ports:
- `clock`, in, 1: single clock; all state changes on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: generate when 1; hold and idle when 0.
- `mode`, in, 2: polynomial select. 0 = PRBS7 (x^7+x^6+1); 1 = PRBS15 (x^15+x^14+1); 2 = PRBS23 (x^23+x^18+1); 3 = PRBS31 (x^31+x^28+1).
- `load`, in, 1: one-cycle pulse that loads `seed` and latches `mode`.
- `seed`, in, 31: seed value; only the low N bits are used, where N is the polynomial length.
- `out_data`, out, W: generated word; the first-generated bit is in the MSB.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: downstream accepts the word.
- `word_count`, out, CNT_W: number of accepted words since reset or the last load.
- `busy`, out, 1: 1 while in RUN.
- `inj_err`, in, 1: error-injection request; present only under `PRBS_ERR_INJECT_EN`.

## Operation
- **State register:** a 31-bit LFSR `s`; only bits [N-1:0] are significant.
- **Single bit-step:** fb = s[N-1] ^ s[T-1], where (N,T) is (7,6), (15,14), (23,18) or (31,28). Then s <= {s[N-2:0], fb}, and fb is the output bit.
- **Per word:** W bit-steps are chained combinationally. Bit k of the word (k = W-1 down to 0) is the (W-k)-th fb.
- **Active mode:** the polynomial in use is `mode_q`, latched only on `load`. `mode` changes without `load` are ignored.
- **Zero-seed guard:** if seed[N-1:0] == 0, the loaded state is all ones in [N-1:0]. The upper bits of `s` are always cleared on load.
- **FSM states:** IDLE and RUN.
  - IDLE -> RUN when `enable`=1 and `load`=0.
  - RUN -> IDLE when `enable`=0.
- **Output handshake:** in RUN, when `out_valid`=0 or `out_ready`=1, the next word is registered into `out_data`, `out_valid` is set to 1, and `s` advances W steps.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `out_data`, `s` and `word_count` hold.
- **Word counter:** `word_count` increments on each cycle with `out_valid` & `out_ready`, and wraps modulo 2^CNT_W.
- **Entering IDLE:** `out_valid` clears when the FSM enters IDLE, and the pending word is discarded. `s` is kept, so the sequence resumes seamlessly on re-enable.
- **Load priority:** `load` overrides everything in that cycle:
  - `s` <= guarded seed; `mode_q` <= `mode`;
  - `out_valid` <= 0; `word_count` <= 0;
  - FSM -> IDLE.
- **Reset values:** `s` = 31'h7FFF_FFFF, `mode_q` = 0, `out_data` = 0, `out_valid` = 0, `word_count` = 0, `busy` = 0, FSM = IDLE.

## Timing
- Latency from `enable` rising (FSM in IDLE) to the first `out_valid`=1 is 2 edges: IDLE->RUN, then the first word is registered.
- From RUN, sustained throughput is one word per clock while `out_ready`=1.
- A `load` followed by `enable` held high: the first word of the new seed is valid 2 cycles after the load edge.
- If `load` and `out_ready` arrive in the same cycle as a valid word, that word counts as not accepted: `word_count` is 0 after the edge.
- Reset mid-operation clears all state asynchronously. The first word after reset is the reset-seed sequence.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `PRBS_ERR_INJECT_EN` defined:
  - the `inj_err` port exists;
  - when a word is registered in a cycle with `inj_err`=1, the MSB of that word is inverted;
  - `s` is not affected, so only one bit error is produced;
  - requests arriving while the output is stalled are held pending and applied to the next registered word;
  - at most one pending request is held at a time.
- Not defined: the port is absent and output is always the pure sequence.

## Test plan
- W=8, mode=0, load seed 7'h7F, enable=1, ready=1 -> first word 8'h02. The sequence repeats exactly every 127 bits, and `word_count`=127 after 127 words.
- W=1, mode=3, seed 0 -> all-ones state is substituted. There are no all-zero runs longer than 30 bits, and the period is 2^31-1 (checked against a reference model for 10^6 bits).
- `out_ready` toggled randomly for 500 cycles -> the accepted-word stream is identical to the run with ready=1, and `out_data` is stable whenever valid=1 and ready=0.
- `enable` dropped mid-stream for 5 cycles, then restored -> `out_valid`=0 while low. The resumed sequence continues from the discarded word.
- `reset_n` asserted asynchronously mid-word -> all outputs are 0 immediately. After release, `s` = 31'h7FFF_FFFF and `mode_q`=0.
- `PRBS_ERR_INJECT_EN`, `inj_err` pulse at word 10 -> exactly one bit error (the MSB of word 10) against the reference, and word 11 onward is error-free.
